// File: rtl/hh_fixed_pkg.sv
// Shared Q8.8 fixed-point constants, sample payload, FSM states and saturation helper
// for the Hodgkin-Huxley neuron core.
package hh_fixed_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned SUM_W     = 18;
  localparam int unsigned PROD_W    = 34;
  localparam int unsigned ACC_W     = 35;

  localparam logic signed [DATA_W-1:0] V_REST_Q   = 16'shBF00;
  localparam logic signed [DATA_W-1:0] SPIKE_TH_Q = 16'sh0000;
  localparam logic signed [DATA_W-1:0] REARM_TH_Q = 16'shD800;
  localparam logic signed [DATA_W-1:0] Q_MAX      = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q_MIN      = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_MUL  = 2'd2,
    ST_UPD  = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] dt;
    logic signed [DATA_W-1:0] i_na;
    logic signed [DATA_W-1:0] i_k;
    logic signed [DATA_W-1:0] i_leak;
    logic signed [DATA_W-1:0] i_ext;
  } sample_t;

  // Clamp a wide signed value into Q8.8 range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] x);
    if (x > ACC_W'(Q_MAX)) begin
      sat16 = Q_MAX;
    end else if (x < ACC_W'(Q_MIN)) begin
      sat16 = Q_MIN;
    end else begin
      sat16 = x[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/spike_detector.sv
// Hysteretic action-potential detector: fires once per upward crossing of SPIKE_TH,
// re-arms only after V falls below REARM_TH, and keeps a saturating spike count.
module spike_detector
  import hh_fixed_pkg::*;
#(
  parameter logic signed [15:0] SPIKE_TH = SPIKE_TH_Q,
  parameter logic signed [15:0] REARM_TH = REARM_TH_Q
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic [15:0] v_new,
  output logic        spike,
  output logic [15:0] spike_count
);

  logic                     armed_q, armed_d;
  logic                     spike_q, spike_d;
  logic [DATA_W-1:0]        count_q, count_d;
  logic signed [DATA_W-1:0] v_s;

  assign v_s = v_new;

  always_comb begin
    armed_d = armed_q;
    spike_d = 1'b0;
    count_d = count_q;
    if (upd) begin
      if (armed_q && (v_s >= SPIKE_TH)) begin
        spike_d = 1'b1;
        armed_d = 1'b0;
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
      end else if (!armed_q && (v_s < REARM_TH)) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b1;
      spike_q <= 1'b0;
      count_q <= '0;
    end else begin
      armed_q <= armed_d;
      spike_q <= spike_d;
      count_q <= count_d;
    end
  end

  assign spike       = spike_q;
  assign spike_count = count_q;

endmodule

// File: rtl/membrane_integrator.sv
// Forward-Euler membrane-potential integrator: V += (i_ext - i_na - i_k - i_leak) * dt / C,
// one sample per four cycles through a SUM / MUL / UPD pipeline driven by a small FSM.
module membrane_integrator
  import hh_fixed_pkg::*;
#(
  parameter logic signed [15:0] V_REST   = V_REST_Q,
  parameter logic signed [15:0] SPIKE_TH = SPIKE_TH_Q,
  parameter logic signed [15:0] REARM_TH = REARM_TH_Q,
  parameter int unsigned        CM_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dt,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] i_na,
  input  logic [15:0] i_k,
  input  logic [15:0] i_leak,
  input  logic [15:0] i_ext,
  output logic [15:0] V,
  output logic        v_valid,
  output logic        spike,
  output logic [15:0] spike_count
);

  state_e                   state_q, state_d;
  sample_t                  smp_q, smp_d;
  logic signed [SUM_W-1:0]  s_q, s_d;
  logic signed [PROD_W-1:0] p_q, p_d;
  logic signed [DATA_W-1:0] v_q, v_d;
  logic                     v_valid_q, v_valid_d;

  logic signed [PROD_W-1:0] d_c;
  logic signed [ACC_W-1:0]  acc_c;
  logic signed [DATA_W-1:0] v_new_c;
  logic                     upd_c;

  // Arithmetic shift floors toward -inf; the 35-bit sum cannot overflow before clamping.
  assign d_c     = p_q >>> (FRAC_BITS + CM_SHIFT);
  assign acc_c   = ACC_W'(v_q) + ACC_W'(d_c);
  assign v_new_c = sat16(acc_c);

  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    s_d       = s_q;
    p_d       = p_q;
    v_d       = v_q;
    v_valid_d = 1'b0;
    upd_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          smp_d.dt     = dt;
          smp_d.i_na   = i_na;
          smp_d.i_k    = i_k;
          smp_d.i_leak = i_leak;
          smp_d.i_ext  = i_ext;
          state_d      = ST_SUM;
        end
      end
      ST_SUM: begin
        s_d     = SUM_W'(smp_q.i_ext) - SUM_W'(smp_q.i_na)
                - SUM_W'(smp_q.i_k)   - SUM_W'(smp_q.i_leak);
        state_d = ST_MUL;
      end
      ST_MUL: begin
        p_d     = PROD_W'(s_q) * PROD_W'(smp_q.dt);
        state_d = ST_UPD;
      end
      ST_UPD: begin
        v_d       = v_new_c;
        v_valid_d = 1'b1;
        upd_c     = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      smp_q     <= '0;
      s_q       <= '0;
      p_q       <= '0;
      v_q       <= V_REST;
      v_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_q     <= smp_d;
      s_q       <= s_d;
      p_q       <= p_d;
      v_q       <= v_d;
      v_valid_q <= v_valid_d;
    end
  end

  spike_detector #(
    .SPIKE_TH (SPIKE_TH),
    .REARM_TH (REARM_TH)
  ) u_spike_detector (
    .clk         (clk),
    .rst         (rst),
    .upd         (upd_c),
    .v_new       (v_new_c),
    .spike       (spike),
    .spike_count (spike_count)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign V        = v_q;
  assign v_valid  = v_valid_q;

endmodule

// File: tb/tb_membrane_integrator.sv
// Scoreboard bench for membrane_integrator: directed samples push hand-computed
// expectations; a monitor pops and compares on every v_valid pulse.
module tb_membrane_integrator;

  typedef struct {
    logic [15:0] v;
    logic        spk;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dt = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] i_na = '0, i_k = '0, i_leak = '0, i_ext = '0;
  logic [15:0] v;
  logic        v_valid, spike;
  logic [15:0] spike_count;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_hist[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  membrane_integrator dut (
    .clk         (clk),
    .rst         (rst),
    .dt          (dt),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .i_na        (i_na),
    .i_k         (i_k),
    .i_leak      (i_leak),
    .i_ext       (i_ext),
    .V           (v),
    .v_valid     (v_valid),
    .spike       (spike),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Acceptance recorder: edge index of every handshake.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      acc_q.push_back(cyc);
      acc_hist.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  // Monitor: compare every V update against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (v_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_v_valid: got V=%h with no pending sample", v);
      end else begin
        e = exp_q.pop_front();
        check("V", 32'(v), 32'(e.v));
        check("spike", 32'(spike), 32'(e.spk));
        check("spike_count", 32'(spike_count), 32'(e.cnt));
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          check("latency", 32'(cyc - a), 32'd4);
        end
      end
    end else if (spike) begin
      n_vec++;
      n_miss++;
      $display("FAIL spike_without_v_valid: got spike=1 expected 0");
    end
  end

  task automatic scramble();
    i_ext  = 16'($urandom);
    i_na   = 16'($urandom);
    i_k    = 16'($urandom);
    i_leak = 16'($urandom);
    dt     = 16'($urandom);
  endtask

  task automatic send(input logic [15:0] ext, input logic [15:0] na, input logic [15:0] k,
                      input logic [15:0] leak, input logic [15:0] dtv, input bit push,
                      input logic [15:0] ev, input logic es, input logic [15:0] ec);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
    i_ext = ext; i_na = na; i_k = k; i_leak = leak; dt = dtv;
    in_valid = 1'b1;
    if (push) exp_q.push_back('{ev, es, ec});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic flush();
    exp_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    // Power-on reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_V", 32'(v), 32'h0000BF00);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(spike_count), 32'd0);
    check("rst_v_valid", 32'(v_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single step: s=2560, p=66560, d=260 -> -16640+260 = -16380
    send(16'h0A00, 16'h0000, 16'h0000, 16'h0000, 16'h001A, 1'b1, 16'hC004, 1'b0, 16'd0);
    drain();
    // Floor: p=-1 -> d=-1
    send(16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 1'b1, 16'hC003, 1'b0, 16'd0);
    // Hysteresis with dt=1.0, so d = s
    send(16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 16'h0003, 1'b1, 16'd1);
    send(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 16'h0103, 1'b0, 16'd1);
    send(16'h0000, 16'h1F03, 16'h0000, 16'h0000, 16'h0100, 1'b1, 16'hE200, 1'b0, 16'd1);
    send(16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 16'h0200, 1'b0, 16'd1);
    send(16'h0000, 16'h3400, 16'h0000, 16'h0000, 16'h0100, 1'b1, 16'hCE00, 1'b0, 16'd1);
    send(16'h3300, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 16'h0100, 1'b1, 16'd2);
    drain();

    // Asynchronous reset mid-run, away from any edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    flush();
    #1;
    check("async_rst_V", 32'(v), 32'h0000BF00);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_count", 32'(spike_count), 32'd0);
    check("async_rst_v_valid", 32'(v_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation with in_valid held high: accepts at k, k+4, k+8
    @(negedge clk);
    base = acc_hist.size();
    i_ext = 16'h7FFF; i_na = 16'h8000; i_k = 16'h8000; i_leak = 16'h8000; dt = 16'h7FFF;
    exp_q.push_back('{16'h7FFF, 1'b1, 16'd1});
    exp_q.push_back('{16'h7FFF, 1'b0, 16'd1});
    exp_q.push_back('{16'h7FFF, 1'b0, 16'd1});
    in_valid = 1'b1;
    n = 0;
    while (acc_hist.size() < base + 3 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    scramble();
    if (acc_hist.size() >= base + 3) begin
      check("throughput_1", 32'(acc_hist[base+1] - acc_hist[base]), 32'd4);
      check("throughput_2", 32'(acc_hist[base+2] - acc_hist[base+1]), 32'd4);
    end else begin
      check("hold_accept_count", 32'(acc_hist.size() - base), 32'd3);
    end
    drain();
    // Negative clamp re-arms; positive clamp then fires a second spike
    send(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h8000, 1'b0, 16'd1);
    send(16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'd2);
    drain();

    // Abort: reset while the sample sits in MUL
    send(16'h0A00, 16'h0000, 16'h0000, 16'h0000, 16'h001A, 1'b0, 16'h0, 1'b0, 16'd0);
    @(posedge clk);
    #2;
    check("abort_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    flush();
    #1;
    check("abort_V", 32'(v), 32'h0000BF00);
    check("abort_v_valid", 32'(v_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_V_hold", 32'(v), 32'h0000BF00);
    check("abort_count", 32'(spike_count), 32'd0);

    // First sample after release proceeds normally
    send(16'h0A00, 16'h0000, 16'h0000, 16'h0000, 16'h001A, 1'b1, 16'hC004, 1'b0, 16'd0);
    drain();
    repeat (4) @(negedge clk);
    check("final_V_hold", 32'(v), 32'h0000C004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
